// File: rtl/envelope_gen_pkg.sv
// Shared types and constants for the envelope generator.
// Optional sustain behaviour is selected with the ENVGEN_SUSTAIN_EN macro.
package envelope_gen_pkg;

  localparam int ENVELOPE_LEN         = 4;
  localparam int ENVELOPE_RESET_BIT   = 0;
  localparam int ENVELOPE_RELEASE_BIT = 1;
  localparam int ENV_LEVEL_W          = 16;
  localparam int ENV_RATE_SHIFT       = 4;
  localparam int STAGE_W              = (ENVELOPE_LEN > 1) ? $clog2(ENVELOPE_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } env_state_t;

  // rate is signed two's complement, duration counts sample ticks
  typedef struct packed {
    logic [7:0] rate;
    logic [7:0] duration;
  } envelope_t;

endpackage

// File: rtl/envelope_gen_if.sv
// Control/output bundle between the control unit, one envelope generator and the mixer.
// Optional sustain behaviour is selected with the ENVGEN_SUSTAIN_EN macro.
interface envelope_gen_if;
  import envelope_gen_pkg::*;

  // sample_en is a valid-only strobe: the generator is always ready, so every
  // asserted cycle is consumed; all outputs are registered and valid every cycle.
  logic                                 sample_en;
  envelope_t [ENVELOPE_LEN-1:0]         envelopes;
  logic [7:0]                           cmds;
  logic [31:0]                          velocity;
  logic [31:0]                          gain;
  logic [STAGE_W-1:0]                   stage;
  logic                                 active;
  logic                                 done;
  env_state_t                           state;

  modport master (
    output sample_en, envelopes, cmds, velocity,
    input  gain, stage, active, done, state
  );

  modport slave (
    input  sample_en, envelopes, cmds, velocity,
    output gain, stage, active, done, state
  );

endinterface

// File: rtl/envelope_gen_sat_step.sv
// Combinational level step: add a shifted signed rate to an unsigned level and clamp.
// Optional sustain behaviour (ENVGEN_SUSTAIN_EN) does not affect this block.
module env_sat_step #(
  parameter int LEVEL_W    = 16,
  parameter int RATE_SHIFT = 4
) (
  input  logic [LEVEL_W-1:0] level_i,
  input  logic [7:0]         rate_i,
  output logic [LEVEL_W-1:0] level_o
);

  localparam int ACC_W = LEVEL_W + 2;

  logic signed [ACC_W-1:0] delta;
  logic signed [ACC_W-1:0] sum;

  assign delta = $signed({{(ACC_W-8){rate_i[7]}}, rate_i}) <<< RATE_SHIFT;
  assign sum   = $signed({2'b00, level_i}) + delta;

  // two guard bits: the top one flags underflow, the next one overflow
  always_comb begin
    level_o = sum[LEVEL_W-1:0];
    if (sum[ACC_W-1]) begin
      level_o = '0;
    end else if (sum[LEVEL_W]) begin
      level_o = '1;
    end
  end

endmodule

// File: rtl/envelope_gen.sv
// Per-oscillator amplitude envelope: stage table walker, saturating level, velocity-scaled gain.
// Define ENVGEN_SUSTAIN_EN to make zero-duration stages hold until the release command bit.
module envelope_gen
  import envelope_gen_pkg::*;
#(
  parameter int N_STAGES   = ENVELOPE_LEN,
  parameter int LEVEL_W    = ENV_LEVEL_W,
  parameter int RATE_SHIFT = ENV_RATE_SHIFT
) (
  input  logic           clk,
  input  logic           rstn,
  envelope_gen_if.slave  bus
);

  env_state_t         state_q;
  logic [LEVEL_W-1:0] level_q;
  logic [LEVEL_W-1:0] level_d;
  logic [7:0]         cnt_q;
  logic [STAGE_W-1:0] stage_q;
  logic               done_q;
  logic               rst_q;
  logic [31:0]        gain_q;
  logic [31:0]        gain_d;

  envelope_t          cur;
  logic               restart;
  logic               run_tick;
  logic               dur_zero;
  logic               dur_end;
  logic               zero_adv;
  logic               advance;
  logic               last_stage;
  logic               unused_bits;

  assign cur        = bus.envelopes[stage_q];
  assign restart    = bus.cmds[ENVELOPE_RESET_BIT] & ~rst_q;
  assign run_tick   = (state_q == RUN) & bus.sample_en & ~restart;
  assign dur_zero   = (cur.duration == 8'd0);
  // >= rather than == so a duration lowered below the count advances at once
  assign dur_end    = ({1'b0, cnt_q} + 9'd1) >= {1'b0, cur.duration};
  assign last_stage = (stage_q == STAGE_W'(N_STAGES - 1));

`ifdef ENVGEN_SUSTAIN_EN
  assign zero_adv = bus.cmds[ENVELOPE_RELEASE_BIT];
`else
  assign zero_adv = 1'b1;
`endif

  assign advance = run_tick & (dur_zero ? zero_adv : dur_end);
  assign gain_d  = 32'(level_q) * {16'b0, bus.velocity[15:0]};

  env_sat_step #(
    .LEVEL_W    (LEVEL_W),
    .RATE_SHIFT (RATE_SHIFT)
  ) u_step (
    .level_i (level_q),
    .rate_i  (cur.rate),
    .level_o (level_d)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      level_q <= '0;
      cnt_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      rst_q   <= 1'b0;
      gain_q  <= '0;
    end else begin
      rst_q  <= bus.cmds[ENVELOPE_RESET_BIT];
      done_q <= 1'b0;
      gain_q <= gain_d;
      if (restart) begin
        state_q <= RUN;
        stage_q <= '0;
        cnt_q   <= '0;
        level_q <= '0;
      end else if (run_tick) begin
        if (dur_zero) begin
          cnt_q <= '0;
        end else begin
          level_q <= level_d;
          cnt_q   <= dur_end ? 8'd0 : cnt_q + 8'd1;
        end
        if (advance) begin
          if (last_stage) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            stage_q <= stage_q + 1'b1;
          end
        end
      end
    end
  end

  assign bus.gain   = gain_q;
  assign bus.stage  = stage_q;
  assign bus.active = (state_q == RUN);
  assign bus.done   = done_q;
  assign bus.state  = state_q;

  assign unused_bits = ^{bus.velocity[31:16], bus.cmds};

endmodule

// File: tb/tb_envelope_gen.sv
// Directed bench for envelope_gen: driver pushes expected observations, a monitor pops and compares.
// Compile with ENVGEN_SUSTAIN_EN to exercise the sustain variant of stage 1.
module tb_envelope_gen;
  import envelope_gen_pkg::*;

  localparam int EXP_W = 36;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic obs  = 1'b0;

  logic [EXP_W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  envelope_gen_if bus ();

  envelope_gen dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  function automatic logic [EXP_W-1:0] mk(input logic [1:0] st, input logic act,
                                          input logic dn, input logic [31:0] g);
    return {st, act, dn, g};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  // monitor: stage/active/done one edge after the event, gain one edge later
  initial begin : monitor
    logic [EXP_W-1:0] e;
    forever begin
      @(posedge clk);
      if (obs) begin
        @(negedge clk);
        chk("exp_avail", 32'(exp_q.size() != 0), 32'd1);
        e = '0;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        chk("stage", 32'(bus.stage), 32'(e[35:34]));
        chk("active", 32'(bus.active), 32'(e[33]));
        chk("done", 32'(bus.done), 32'(e[32]));
        @(negedge clk);
        chk("gain", bus.gain, e[31:0]);
        chk("done_pulse", 32'(bus.done), 32'd0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  task automatic set_env(input int s, input logic [7:0] rate, input logic [7:0] dur);
    bus.envelopes[s] = {rate, dur};
  endtask

  task automatic tick(input logic [EXP_W-1:0] e);
    exp_q.push_back(e);
    @(negedge clk);
    bus.sample_en = 1'b1;
    obs           = 1'b1;
    @(negedge clk);
    bus.sample_en = 1'b0;
    obs           = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic restart(input logic with_tick, input logic [EXP_W-1:0] e);
    exp_q.push_back(e);
    @(negedge clk);
    bus.cmds[ENVELOPE_RESET_BIT] = 1'b1;
    bus.sample_en                = with_tick;
    obs                          = 1'b1;
    @(negedge clk);
    bus.cmds[ENVELOPE_RESET_BIT] = 1'b0;
    bus.sample_en                = 1'b0;
    obs                          = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic stage1_pass(input logic [31:0] g);
`ifdef ENVGEN_SUSTAIN_EN
    for (int i = 0; i < 20; i++) tick(mk(2'd1, 1'b1, 1'b0, g));
    bus.cmds[ENVELOPE_RELEASE_BIT] = 1'b1;
    tick(mk(2'd2, 1'b1, 1'b0, g));
    bus.cmds[ENVELOPE_RELEASE_BIT] = 1'b0;
`else
    tick(mk(2'd2, 1'b1, 1'b0, g));
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : driver
    int lvl;
    bus.sample_en = 1'b0;
    bus.cmds      = 8'h00;
    bus.velocity  = 32'h0000_FFFF;
    set_env(0, 8'd16, 8'd4);
    set_env(1, 8'd0,  8'd0);
    set_env(2, 8'd64, 8'd20);
    set_env(3, 8'd16, 8'd2);

    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_gain", bus.gain, 32'd0);
    chk("rst_stage", 32'(bus.stage), 32'd0);
    chk("rst_active", 32'(bus.active), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);

    // ramp at +16 per tick, velocity full scale
    restart(1'b0, mk(2'd0, 1'b1, 1'b0, 32'd0));
    tick(mk(2'd0, 1'b1, 1'b0, 32'h00FF_FF00));
    tick(mk(2'd0, 1'b1, 1'b0, 32'h01FF_FE00));
    tick(mk(2'd0, 1'b1, 1'b0, 32'h02FF_FD00));
    tick(mk(2'd1, 1'b1, 1'b0, 32'h03FF_FC00));

    // upper velocity bits must be ignored
    bus.velocity = 32'h5A5A_0001;
    stage1_pass(32'h0000_0400);
    for (int k = 1; k <= 11; k++) tick(mk(2'd2, 1'b1, 1'b0, 32'h400 + 32'(k) * 32'h400));

    // restart coincident with a tick: restart wins, tick dropped
    restart(1'b1, mk(2'd0, 1'b1, 1'b0, 32'd0));

    // overflow clamp
    set_env(0, 8'd127, 8'd255);
    lvl = 0;
    for (int k = 0; k < 36; k++) begin
      lvl = (lvl + 2032 > 65535) ? 65535 : lvl + 2032;
      tick(mk(2'd0, 1'b1, 1'b0, 32'(lvl)));
    end

    // underflow clamp from 0x0500
    restart(1'b0, mk(2'd0, 1'b1, 1'b0, 32'd0));
    set_env(0, 8'd16, 8'd255);
    for (int k = 1; k <= 5; k++) tick(mk(2'd0, 1'b1, 1'b0, 32'(k) * 32'h100));
    set_env(0, 8'h80, 8'd255);
    for (int k = 0; k < 3; k++) tick(mk(2'd0, 1'b1, 1'b0, 32'd0));

    // duration lowered below count: advance on the next tick
    set_env(0, 8'h80, 8'd3);
    tick(mk(2'd1, 1'b1, 1'b0, 32'd0));
    stage1_pass(32'd0);
    set_env(2, 8'd64, 8'd1);
    tick(mk(2'd3, 1'b1, 1'b0, 32'h400));
    tick(mk(2'd3, 1'b1, 1'b0, 32'h500));
    tick(mk(2'd3, 1'b0, 1'b1, 32'h600));
    tick(mk(2'd3, 1'b0, 1'b0, 32'h600));
    tick(mk(2'd3, 1'b0, 1'b0, 32'h600));

    // async reset in the middle of a run
    set_env(0, 8'd16, 8'd4);
    restart(1'b0, mk(2'd0, 1'b1, 1'b0, 32'd0));
    tick(mk(2'd0, 1'b1, 1'b0, 32'h100));
    drain();
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_gain", bus.gain, 32'd0);
    chk("arst_stage", 32'(bus.stage), 32'd0);
    chk("arst_active", 32'(bus.active), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    tick(mk(2'd0, 1'b0, 1'b0, 32'd0));

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
